// File: rtl/w_update_ctrl.sv
// Radix-2 SRT-style residual update controller.
// Walks the residual RAM one word per iteration and emits signed quotient digits.
module w_update_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [DATA_WIDTH-1:0] w_init,
    input  logic [ADDR_WIDTH-1:0] num_iter,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    output logic [1:0]            q_digit,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  sat
);
    localparam int W = DATA_WIDTH;
    localparam int A = ADDR_WIDTH;

    localparam logic signed [W+1:0] WMAX = (W+2)'(2**(W-1) - 1);
    localparam logic signed [W+1:0] WMIN = ~WMAX;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0] d_reg;
    logic [W-1:0] w_reg;
    logic [A-1:0] n_reg;
    logic [A:0]   j;

    logic signed [W+1:0] t;
    logic signed [W+1:0] h;
    logic signed [W+1:0] dext;
    logic signed [W+1:0] w_full;
    logic [W-1:0]        w_sat;
    logic                q_pos;
    logic                q_neg;
    logic                ovf_hi;
    logic                ovf_lo;
    logic                ovf;

    // Residual datapath: 10-bit signed so 2*w +/- D never wraps before clamping.
    assign t    = {ram_q[W-1], ram_q, 1'b0};
    assign h    = {3'b000, d_reg[W-1:1]};
    assign dext = {2'b00, d_reg};

    assign q_pos = (t >= h);
    assign q_neg = (t < -h);

    always_comb begin
        w_full = t;
        if (q_pos) begin
            w_full = t - dext;
        end else if (q_neg) begin
            w_full = t + dext;
        end
    end

    assign ovf_hi = (w_full > WMAX);
    assign ovf_lo = (w_full < WMIN);
    assign ovf    = ovf_hi | ovf_lo;

    always_comb begin
        w_sat = w_full[W-1:0];
        if (ovf_hi) begin
            w_sat = WMAX[W-1:0];
        end else if (ovf_lo) begin
            w_sat = WMIN[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            d_reg <= '0;
            w_reg <= '0;
            n_reg <= '0;
            j     <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        d_reg <= divisor;
                        w_reg <= w_init;
                        n_reg <= num_iter;
                        sat   <= 1'b0;
                    end
                end
                INIT: j <= (A+1)'(1);
                CALC: begin
                    j <= j + (A+1)'(1);
                    if (ovf) begin
                        sat <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        ram_data       = '0;
        ram_write_addr = '0;
        ram_read_addr  = '0;
        ram_we         = 1'b0;
        q_digit        = 2'b00;
        q_valid        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_data  = w_reg;
                state_nxt = (n_reg != '0) ? READ : DONE;
            end
            READ: begin
                busy          = 1'b1;
                ram_read_addr = j[A-1:0] - A'(1);
                state_nxt     = CALC;
            end
            CALC: begin
                busy           = 1'b1;
                ram_we         = 1'b1;
                ram_write_addr = j[A-1:0];
                ram_data       = w_sat;
                q_valid        = 1'b1;
                q_digit        = q_pos ? 2'b01 : (q_neg ? 2'b11 : 2'b00);
                state_nxt      = (j < {1'b0, n_reg}) ? READ : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_w_update_ctrl.sv
// Bench for w_update_ctrl: registered-read RAM, per-cycle trace model,
// and literal expectations for the reference recurrences.
module tb_w_update_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] divisor;
    logic [7:0] w_init;
    logic [6:0] num_iter;
    logic [7:0] ram_q;
    logic [7:0] ram_data;
    logic [6:0] ram_write_addr;
    logic [6:0] ram_read_addr;
    logic       ram_we;
    logic [1:0] q_digit;
    logic       q_valid;
    logic       busy;
    logic       done;
    logic       sat;

    always #5 clk = ~clk;

    w_update_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .divisor        (divisor),
        .w_init         (w_init),
        .num_iter       (num_iter),
        .ram_q          (ram_q),
        .ram_data       (ram_data),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_we         (ram_we),
        .q_digit        (q_digit),
        .q_valid        (q_valid),
        .busy           (busy),
        .done           (done),
        .sat            (sat)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       qv;
        logic [1:0] qd;
        logic       we;
        logic [6:0] wa;
        logic [7:0] wd;
        logic [6:0] ra;
        logic       sat;
    } obs_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } lit_t;

    obs_t       got;
    obs_t       cur;
    obs_t       exp_q[$];
    lit_t       lit_q[$];
    logic [1:0] qlog[$];
    bit         armed = 1'b0;
    int         checks = 0;
    int         errors = 0;

    assign got = {busy, done, q_valid, q_digit, ram_we,
                  ram_write_addr, ram_data, ram_read_addr, sat};

    logic [7:0] mem [128];
    logic [7:0] ref_mem [128];
    logic [6:0] raddr_q;
    logic       fill;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h55;
        end else if (ram_we) begin
            mem[ram_write_addr] <= ram_data;
        end
        raddr_q <= ram_read_addr;
    end

    assign ram_q = mem[raddr_q];

    // Expected per-cycle trace of one run, from the recurrence itself.
    task automatic build(input int d, input int w, input int n);
        obs_t e;
        int   wp, t, q, wn;
        bit   s, o;
        s = 1'b0;
        e = '0;
        e.busy = 1'b1;
        e.we = 1'b1;
        e.wd = 8'(w);
        exp_q.push_back(e);
        wp = w;
        for (int k = 1; k <= n; k++) begin
            e = '0;
            e.busy = 1'b1;
            e.ra = 7'(k - 1);
            e.sat = s;
            exp_q.push_back(e);
            t = 2 * wp;
            if (t >= d / 2) q = 1;
            else if (t < -(d / 2)) q = -1;
            else q = 0;
            wn = t - q * d;
            o = (wn > 127) || (wn < -128);
            if (wn > 127) wn = 127;
            if (wn < -128) wn = -128;
            e = '0;
            e.busy = 1'b1;
            e.we = 1'b1;
            e.wa = 7'(k);
            e.wd = 8'(wn);
            e.qv = 1'b1;
            e.qd = (q == 1) ? 2'b01 : ((q == -1) ? 2'b11 : 2'b00);
            e.sat = s;
            exp_q.push_back(e);
            s = s | o;
            wp = wn;
        end
        e = '0;
        e.done = 1'b1;
        e.sat = s;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        logic s;
        if (fill) begin
            for (int i = 0; i < 128; i++) ref_mem[i] = 8'h55;
        end
        if (rst) begin
            exp_q.delete();
            cur = '0;
            armed = 1'b1;
        end else if (armed) begin
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else if (start && !cur.done) begin
                build(int'(divisor), int'($signed(w_init)), int'(num_iter));
                cur = exp_q.pop_front();
            end else begin
                s = cur.sat;
                cur = '0;
                cur.sat = s;
            end
            if (cur.we) ref_mem[cur.wa] = cur.wd;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (got !== cur) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, got, cur);
            end
            if (q_valid) qlog.push_back(q_digit);
        end
        while (lit_q.size() > 0) begin
            lit_t r;
            r = lit_q.pop_front();
            checks++;
            if (r.got != r.want) begin
                errors++;
                $display("FAIL %s got=%0d want=%0d", r.name, r.got, r.want);
            end
        end
    end

    task automatic lit(input string name, input int g, input int w);
        lit_t r;
        r.name = name;
        r.got = g;
        r.want = w;
        lit_q.push_back(r);
    endtask

    function automatic int ram_diff();
        int n;
        n = 0;
        for (int i = 0; i < 128; i++) begin
            if (mem[i] !== ref_mem[i]) n++;
        end
        return n;
    endfunction

    task automatic fill_ram();
        fill = 1'b1;
        @(posedge clk);
        #1 fill = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] d, input logic [7:0] w,
                       input logic [6:0] n, input int pulse_at,
                       input int rst_at, input bit chain, output int c);
        divisor = d;
        w_init = w;
        num_iter = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        c = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (done) begin
                c = i;
                if (chain) start = 1'b1;
                break;
            end
            if (i == pulse_at) begin
                start = 1'b1;
                divisor = d + 8'd37;
                w_init = ~w;
            end else begin
                start = 1'b0;
            end
            rst = (i == rst_at);
            if (rst_at > 0 && i == rst_at + 4) break;
        end
    endtask

    int c;
    int b;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        divisor = '0;
        w_init = '0;
        num_iter = '0;
        fill = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        lit("reset_outputs", int'(got), 0);

        fill_ram();
        b = qlog.size();
        run(8'd64, 8'd40, 7'd4, 0, 0, 1'b0, c);
        lit("a_done_cycle", c, 10);
        lit("a_sat", int'(sat), 0);
        idle();
        lit("a_q_count", qlog.size() - b, 4);
        lit("a_q1", int'(qlog[b]), 1);
        lit("a_q2", int'(qlog[b+1]), 1);
        lit("a_q3", int'(qlog[b+2]), 3);
        lit("a_q4", int'(qlog[b+3]), 0);
        lit("a_ram0", int'(mem[0]), 8'h28);
        lit("a_ram1", int'(mem[1]), 8'h10);
        lit("a_ram2", int'(mem[2]), 8'hE0);
        lit("a_ram3", int'(mem[3]), 8'h00);
        lit("a_ram4", int'(mem[4]), 8'h00);
        lit("a_ram5", int'(mem[5]), 8'h55);

        run(8'd0, 8'd100, 7'd1, 0, 0, 1'b0, c);
        lit("b_done_cycle", c, 4);
        lit("b_sat", int'(sat), 1);
        repeat (3) idle();
        lit("b_ram1", int'(mem[1]), 8'h7F);
        lit("b_sat_held", int'(sat), 1);

        run(8'd0, 8'h9C, 7'd2, 0, 0, 1'b0, c);
        lit("e_done_cycle", c, 6);
        idle();
        lit("e_ram1", int'(mem[1]), 8'h80);
        lit("e_ram2", int'(mem[2]), 8'h80);
        lit("e_sat", int'(sat), 1);

        b = qlog.size();
        run(8'd7, 8'd5, 7'd0, 0, 0, 1'b1, c);
        lit("c_done_cycle", c, 2);
        lit("c_ram0", int'(mem[0]), 8'h05);
        lit("c_sat", int'(sat), 0);
        idle();
        lit("c_q_count", qlog.size() - b, 0);
        run(8'd100, 8'hC4, 7'd2, 0, 0, 1'b0, c);
        lit("d_done_cycle", c, 6);
        idle();
        lit("d_q_count", qlog.size() - b, 2);
        lit("d_q1", int'(qlog[b]), 3);
        lit("d_q2", int'(qlog[b+1]), 0);
        lit("d_ram0", int'(mem[0]), 8'hC4);
        lit("d_ram1", int'(mem[1]), 8'hEC);
        lit("d_ram2", int'(mem[2]), 8'hD8);

        b = qlog.size();
        run(8'd64, 8'd40, 7'd4, 3, 0, 1'b0, c);
        lit("f_done_cycle", c, 10);
        idle();
        lit("f_q3", int'(qlog[b+2]), 3);
        lit("f_ram2", int'(mem[2]), 8'hE0);

        fill_ram();
        b = qlog.size();
        run(8'd64, 8'd40, 7'd4, 0, 5, 1'b0, c);
        lit("g_no_done", c, 0);
        idle();
        lit("g_q_count", qlog.size() - b, 2);
        lit("g_ram3", int'(mem[3]), 8'h55);
        lit("g_ram4", int'(mem[4]), 8'h55);
        lit("g_ram_model", ram_diff(), 0);
        run(8'd64, 8'd40, 7'd4, 0, 0, 1'b0, c);
        lit("g_rerun_done", c, 10);
        idle();
        lit("g_rerun_ram4", int'(mem[4]), 8'h00);

        rst = 1'b1;
        start = 1'b1;
        divisor = 8'd9;
        num_iter = 7'd3;
        idle();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        lit("h_rst_priority_busy", int'(busy), 0);
        repeat (3) idle();

        run(8'd3, 8'd1, 7'd127, 0, 0, 1'b0, c);
        lit("i_done_cycle", c, 256);
        idle();
        lit("i_ram127", int'(mem[127]), 8'hFF);
        lit("i_ram126", int'(mem[126]), 8'h01);
        lit("i_ram0", int'(mem[0]), 8'h01);
        lit("i_ram_model", ram_diff(), 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/w_update_ctrl.md
W_UPDATE_CTRL -- requirements
Module: w_update_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8, residual word width (two's complement); all arithmetic rules below use 8.
REQ-002 Parameter ADDR_WIDTH, 7, residual RAM address width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a recurrence; sampled only in IDLE.
REQ-006 divisor  input  8  divisor D, unsigned; captured at accepted start.
REQ-007 w_init  input  8  initial residual w[0], signed; captured at accepted start.
REQ-008 num_iter  input  7  iteration count N (0..127); captured at accepted start.
REQ-009 ram_q  input  8  residual RAM read data; valid the cycle after ram_read_addr is presented.
REQ-010 ram_data  output  8  residual RAM write data.
REQ-011 ram_write_addr  output  7  residual RAM write address.
REQ-012 ram_read_addr  output  7  residual RAM read address.
REQ-013 ram_we  output  1  residual RAM write enable.
REQ-014 q_digit  output  2  quotient digit: 01=+1, 00=0, 11=-1; 10 never driven.
REQ-015 q_valid  output  1  q_digit valid, one cycle per iteration.
REQ-016 busy  output  1  high from INIT through last CALC.
REQ-017 done  output  1  one-cycle pulse after final iteration.
REQ-018 sat  output  1  sticky: some residual saturated during current run.

Function
REQ-019 FSM states IDLE, INIT, READ, CALC, DONE; IDLE->INIT on start; INIT->READ if N>0 else DONE; READ->CALC; CALC->READ if j<N else DONE; DONE->IDLE.
REQ-020 start outside IDLE is ignored; captured D, w_init, N stay constant for the whole run.
REQ-021 INIT: ram_we=1, ram_write_addr=0, ram_data=w_init; iteration index j set to 1; sat cleared.
REQ-022 READ: ram_read_addr=j-1, ram_we=0.
REQ-023 CALC: t = 2*ram_q as 9-bit signed; h = D>>1 (7-bit, zero-extended).
REQ-024 CALC selection: q=+1 if t >= h; q=-1 if t < -h; else q=0.
REQ-025 CALC update: w_new = t - q*D computed at 10-bit signed, saturated to [-128,127]; saturation sets sat.
REQ-026 CALC: ram_we=1, ram_write_addr=j, ram_data=w_new, q_valid=1, q_digit=q; j increments.
REQ-027 q_digit=00 and q_valid=0 in all states except CALC; ram_we=0 except INIT and CALC.
REQ-028 Timing: start accepted at edge 0 -> INIT in cycle 1; iteration k CALC in cycle 1+2k; done=1 in cycle 2+2N; busy=1 cycles 1..1+2N.
REQ-029 N=127 writes address 127 last; no address wrap occurs.
REQ-030 sat holds its value after DONE until the next accepted start.
REQ-031 start asserted in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.

Reset
REQ-032 rst=1 at a rising edge forces IDLE; all outputs 0 the next cycle; j, captured D, w_init, N cleared.
REQ-033 rst mid-run aborts without done pulse; RAM contents are not modified by reset.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 D=64, w_init=40, N=4 -> q_digit sequence +1,+1,-1,0; RAM[0..4]=40,16,-32,0,0; done in cycle 10; sat=0.
REQ-036 D=0, w_init=100, N=1 -> q=+1, t=200 saturates, RAM[1]=127, sat=1 held after done.
REQ-037 N=0, w_init=5 -> INIT writes RAM[0]=5, no q_valid, done in cycle 2.
REQ-038 start pulsed again during busy with different D -> ignored; results match first D.
REQ-039 rst asserted in cycle 5 of REQ-035 run -> IDLE, no done, no further RAM writes; new start runs cleanly from INIT.
REQ-040 Bench models RAM with registered read address (read data one cycle after address); every CALC compares q_digit and ram_data with a reference model.
